// File: rtl/ioctl_mem_sched.sv
// ioctl_mem_sched: shares one byte-wide memory port between the ARM->FPGA
// download stream (buffered in a small FIFO, always wins) and core reads.
// Ports: clk_sys/reset; ioctl_download/wr/addr/dout in, clkref_n out
// (receiver throttle); core_req/addr in, core_ack/dout out; mem_req/we/
// addr/din out, mem_ack/dout in; core_reset, dl_done, dl_overflow out.
module ioctl_mem_sched #(
  parameter int AW        = 25,
  parameter int FIFO_LOG2 = 2,
  parameter int RST_HOLD  = 16
) (
  input  logic          clk_sys,
  input  logic          reset,
  input  logic          ioctl_download,
  input  logic          ioctl_wr,
  input  logic [AW-1:0] ioctl_addr,
  input  logic [7:0]    ioctl_dout,
  output logic          clkref_n,
  input  logic          core_req,
  input  logic [AW-1:0] core_addr,
  output logic          core_ack,
  output logic [7:0]    core_dout,
  output logic          mem_req,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [7:0]    mem_din,
  input  logic          mem_ack,
  input  logic [7:0]    mem_dout,
  output logic          core_reset,
  output logic          dl_done,
  output logic          dl_overflow
);

  localparam int DEPTH = 1 << FIFO_LOG2;
  localparam int CW    = FIFO_LOG2 + 1;
  localparam logic [CW-1:0]        DEPTH_C   = CW'(DEPTH);
  localparam logic [CW-1:0]        TWO_C     = CW'(2);
  localparam logic [FIFO_LOG2-1:0] PTR_ONE   = FIFO_LOG2'(1);
  localparam logic [15:0]          HOLD_INIT = 16'(RST_HOLD);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WRITE,
    S_READ,
    S_RDONE
  } state_t;

  state_t state_q, state_d;

  logic [AW+7:0]        fifo_q [DEPTH];
  logic [FIFO_LOG2-1:0] wr_ptr_q, wr_ptr_d;
  logic [FIFO_LOG2-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]        count_q, count_d;
  logic [CW-1:0]        free_d;

  logic          clkref_n_q, clkref_n_d;
  logic          mem_req_q, mem_req_d;
  logic          mem_we_q, mem_we_d;
  logic [AW-1:0] mem_addr_q, mem_addr_d;
  logic [7:0]    mem_din_q, mem_din_d;
  logic          core_ack_q, core_ack_d;
  logic [7:0]    core_dout_q, core_dout_d;
  logic          core_reset_q, core_reset_d;
  logic [15:0]   hold_q, hold_d;
  logic          dl_done_q, dl_done_d;
  logic          dl_ovf_q, dl_ovf_d;
  logic          dl_prev_q, dl_prev_d;
  logic          dl_seen_q, dl_seen_d;

  logic          full, empty, push_req, push, pop;
  logic          drained, dl_rise;
  logic [AW+7:0] head;

  assign full     = (count_q == DEPTH_C);
  assign empty    = (count_q == '0);
  assign push_req = ioctl_wr & ioctl_download;
  assign push     = push_req & ~full;
  assign pop      = (state_q == S_WRITE) & mem_ack;
  assign head     = fifo_q[rd_ptr_q];
  assign dl_rise  = ioctl_download & ~dl_prev_q;
  assign drained  = ~ioctl_download & empty & (state_q == S_IDLE);

  // FIFO bookkeeping and receiver throttle
  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    dl_ovf_d   = dl_ovf_q;
    if (push) wr_ptr_d = wr_ptr_q + PTR_ONE;
    if (pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
    count_d = count_q
            + {{(CW-1){1'b0}}, push}
            - {{(CW-1){1'b0}}, pop};
    free_d  = DEPTH_C - count_d;
    // two free slots: the receiver strobes one cycle after seeing low
    clkref_n_d = (free_d < TWO_C);
    if (dl_rise) dl_ovf_d = 1'b0;
    if (push_req & full) dl_ovf_d = 1'b1;
  end

  // core reset hold and download-done pulse
  always_comb begin
    hold_d       = hold_q;
    core_reset_d = core_reset_q;
    dl_prev_d    = ioctl_download;
    dl_done_d    = drained & dl_seen_q;
    dl_seen_d    = dl_seen_q;
    if (ioctl_download)  dl_seen_d = 1'b1;
    else if (drained)    dl_seen_d = 1'b0;
    if (!drained) begin
      hold_d       = HOLD_INIT;
      core_reset_d = 1'b1;
    end else if (hold_q != 16'd0) begin
      hold_d       = hold_q - 16'd1;
      core_reset_d = (hold_q != 16'd1);
    end else begin
      core_reset_d = 1'b0;
    end
  end

  // port arbiter
  always_comb begin
    state_d     = state_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_din_d   = mem_din_q;
    core_dout_d = core_dout_q;
    core_ack_d  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (!empty) begin
          state_d    = S_WRITE;
          mem_req_d  = 1'b1;
          mem_we_d   = 1'b1;
          mem_addr_d = head[AW+7:8];
          mem_din_d  = head[7:0];
        end else if (core_req && !ioctl_download) begin
          state_d    = S_READ;
          mem_req_d  = 1'b1;
          mem_we_d   = 1'b0;
          mem_addr_d = core_addr;
        end
      end
      S_WRITE: begin
        if (mem_ack) begin
          state_d   = S_IDLE;
          mem_req_d = 1'b0;
        end
      end
      S_READ: begin
        if (mem_ack) begin
          state_d     = S_RDONE;
          mem_req_d   = 1'b0;
          core_dout_d = mem_dout;
          core_ack_d  = 1'b1;
        end
      end
      S_RDONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_sys) begin
    if (push) fifo_q[wr_ptr_q] <= {ioctl_addr, ioctl_dout};
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state_q      <= S_IDLE;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      clkref_n_q   <= 1'b1;
      mem_req_q    <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_din_q    <= '0;
      core_ack_q   <= 1'b0;
      core_dout_q  <= '0;
      core_reset_q <= 1'b1;
      hold_q       <= HOLD_INIT;
      dl_done_q    <= 1'b0;
      dl_ovf_q     <= 1'b0;
      dl_prev_q    <= 1'b0;
      dl_seen_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      clkref_n_q   <= clkref_n_d;
      mem_req_q    <= mem_req_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_din_q    <= mem_din_d;
      core_ack_q   <= core_ack_d;
      core_dout_q  <= core_dout_d;
      core_reset_q <= core_reset_d;
      hold_q       <= hold_d;
      dl_done_q    <= dl_done_d;
      dl_ovf_q     <= dl_ovf_d;
      dl_prev_q    <= dl_prev_d;
      dl_seen_q    <= dl_seen_d;
    end
  end

  assign clkref_n    = clkref_n_q;
  assign mem_req     = mem_req_q;
  assign mem_we      = mem_we_q;
  assign mem_addr    = mem_addr_q;
  assign mem_din     = mem_din_q;
  assign core_ack    = core_ack_q;
  assign core_dout   = core_dout_q;
  assign core_reset  = core_reset_q;
  assign dl_done     = dl_done_q;
  assign dl_overflow = dl_ovf_q;

endmodule

// File: tb/tb_ioctl_mem_sched.sv
// tb_ioctl_mem_sched: directed stimulus with an expected-transaction
// scoreboard; a negedge monitor pops and compares memory/core traffic.
module tb_ioctl_mem_sched;

  localparam int AW = 25;

  logic          clk_sys = 1'b0;
  logic          reset = 1'b1;
  logic          ioctl_download = 1'b0;
  logic          ioctl_wr = 1'b0;
  logic [AW-1:0] ioctl_addr = '0;
  logic [7:0]    ioctl_dout = '0;
  logic          core_req = 1'b0;
  logic [AW-1:0] core_addr = '0;
  logic          mem_ack = 1'b0;
  logic [7:0]    mem_dout = '0;
  logic          clkref_n, core_ack, mem_req, mem_we;
  logic          core_reset, dl_done, dl_overflow;
  logic [7:0]    core_dout, mem_din;
  logic [AW-1:0] mem_addr;

  always #5 clk_sys = ~clk_sys;

  ioctl_mem_sched #(.AW(AW), .FIFO_LOG2(2), .RST_HOLD(16)) dut (
    .clk_sys(clk_sys), .reset(reset),
    .ioctl_download(ioctl_download), .ioctl_wr(ioctl_wr),
    .ioctl_addr(ioctl_addr), .ioctl_dout(ioctl_dout),
    .clkref_n(clkref_n),
    .core_req(core_req), .core_addr(core_addr),
    .core_ack(core_ack), .core_dout(core_dout),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_din(mem_din), .mem_ack(mem_ack), .mem_dout(mem_dout),
    .core_reset(core_reset), .dl_done(dl_done),
    .dl_overflow(dl_overflow)
  );

  typedef struct packed {
    logic          we;
    logic [AW-1:0] addr;
    logic [7:0]    data;
  } mtx_t;

  mtx_t       exp_mem[$];
  logic [7:0] exp_rd[$];
  int         n_cmp = 0;
  int         n_err = 0;
  int         dl_done_cnt = 0;
  int         ack_dly = 3;
  bit         ack_hold = 1'b0;
  logic [7:0] rd_val = '0;

  task automatic check(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // memory: acks ack_dly cycles after mem_req rises unless held off
  initial begin
    int cnt;
    cnt = 0;
    forever begin
      @(posedge clk_sys);
      #1;
      mem_ack = 1'b0;
      if (reset || !mem_req) cnt = 0;
      else if (!ack_hold) begin
        cnt++;
        if (cnt >= ack_dly) begin
          mem_ack  = 1'b1;
          mem_dout = rd_val;
          cnt      = 0;
        end
      end
    end
  end

  // occupancy reference for the throttle
  int   occ = 0;
  logic exp_clk = 1'b1;
  bit   live = 1'b0;
  always @(posedge clk_sys) begin
    int n;
    if (reset) begin
      occ     = 0;
      exp_clk = 1'b1;
      live    = 1'b1;
    end else begin
      n = occ;
      if (ioctl_wr && ioctl_download && occ < 4) n++;
      if (mem_req && mem_we && mem_ack) n--;
      occ     = n;
      exp_clk = (occ >= 3);
    end
  end

  // monitor
  logic prev_req = 1'b0;
  logic prev_rack = 1'b0;
  always @(negedge clk_sys) begin
    mtx_t e;
    if (live) begin
      check("clkref_n", {63'd0, clkref_n}, {63'd0, exp_clk});
      if (mem_req === 1'b1 && prev_req !== 1'b1) begin
        if (exp_mem.size() == 0) check("mem_unexpected", 1, 0);
        else begin
          e = exp_mem.pop_front();
          check("mem_we", {63'd0, mem_we}, {63'd0, e.we});
          check("mem_addr", 64'(mem_addr), 64'(e.addr));
          if (e.we) check("mem_din", 64'(mem_din), 64'(e.data));
          else check("read_during_dl", {63'd0, ioctl_download}, 0);
        end
      end
      if (core_ack === 1'b1) begin
        if (exp_rd.size() == 0) check("ack_unexpected", 1, 0);
        else check("core_dout", 64'(core_dout), 64'(exp_rd.pop_front()));
        check("ack_latency", {63'd0, prev_rack}, 1);
      end
      if (dl_done === 1'b1) dl_done_cnt++;
    end
    prev_req  = mem_req;
    prev_rack = mem_req && mem_ack && !mem_we;
  end

  task automatic step();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic push_wr(input logic [AW-1:0] a, input logic [7:0] d);
    mtx_t e;
    e.we = 1'b1; e.addr = a; e.data = d;
    exp_mem.push_back(e);
  endtask

  task automatic send_byte(input logic [AW-1:0] a, input logic [7:0] d);
    int t;
    t = 0;
    while (clkref_n !== 1'b0 && t < 1000) begin
      step();
      t++;
    end
    if (t >= 1000) check("clkref_wait", {63'd0, clkref_n}, 0);
    push_wr(a, d);
    ioctl_wr = 1'b1; ioctl_addr = a; ioctl_dout = d;
    step();
    ioctl_wr = 1'b0;
    step();
  endtask

  // waits for dl_done, then counts cycles until core_reset falls
  task automatic wait_drain_hold();
    int t, n;
    t = 0;
    do begin
      @(negedge clk_sys);
      t++;
    end while (dl_done !== 1'b1 && t < 500);
    check("dl_done_seen", {63'd0, dl_done}, 1);
    n = 0;
    while (core_reset === 1'b1 && n < 200) begin
      @(negedge clk_sys);
      n++;
    end
    check("hold_after_dl", n, 15);
    step();
  endtask

  task automatic do_read(input logic [AW-1:0] a, input logic [7:0] v);
    mtx_t e;
    int t;
    e.we = 1'b0; e.addr = a; e.data = '0;
    exp_mem.push_back(e);
    exp_rd.push_back(v);
    rd_val = v; core_addr = a; core_req = 1'b1;
    t = 0;
    do begin
      @(negedge clk_sys);
      t++;
    end while (core_ack !== 1'b1 && t < 200);
    check("read_ack_seen", {63'd0, core_ack}, 1);
    core_req = 1'b0;
    step();
  endtask

  initial begin
    int n, d0;

    // reset release, no download
    repeat (3) @(posedge clk_sys);
    #1 reset = 1'b0;
    @(negedge clk_sys);
    check("rst_mem_req", {63'd0, mem_req}, 0);
    check("rst_mem_we", {63'd0, mem_we}, 0);
    check("rst_core_ack", {63'd0, core_ack}, 0);
    check("rst_ovf", {63'd0, dl_overflow}, 0);
    check("rst_mem_addr", 64'(mem_addr), 0);
    check("rst_mem_din", 64'(mem_din), 0);
    check("rst_core_dout", 64'(core_dout), 0);
    check("rst_core_reset", {63'd0, core_reset}, 1);
    check("rst_clkref_n", {63'd0, clkref_n}, 1);
    n = 1;
    @(negedge clk_sys);
    check("clkref_after_rel", {63'd0, clkref_n}, 0);
    while (core_reset === 1'b1 && n < 200) begin
      n++;
      @(negedge clk_sys);
    end
    check("rst_hold_len", n, 16);
    check("no_dl_done_rst", dl_done_cnt, 0);
    step();

    // 8-byte download
    ack_dly = 3;
    d0 = dl_done_cnt;
    ioctl_download = 1'b1;
    step();
    for (int i = 0; i < 8; i++) send_byte(AW'(i), 8'hA0 + 8'(i));
    ioctl_download = 1'b0;
    wait_drain_hold();
    check("dl8_done_cnt", dl_done_cnt - d0, 1);
    check("dl8_ovf", {63'd0, dl_overflow}, 0);

    // forced overflow
    ack_dly = 1;
    ack_hold = 1'b1;
    ioctl_download = 1'b1;
    step();
    for (int i = 0; i < 5; i++) begin
      ioctl_wr = 1'b1;
      ioctl_addr = AW'(32'h200 + i);
      ioctl_dout = 8'hB0 + 8'(i);
      if (i < 4) push_wr(ioctl_addr, ioctl_dout);
      step();
    end
    ioctl_wr = 1'b0;
    step();
    check("ovf_set", {63'd0, dl_overflow}, 1);
    repeat (5) step();
    check("ovf_sticky", {63'd0, dl_overflow}, 1);
    ack_hold = 1'b0;
    ioctl_download = 1'b0;
    wait_drain_hold();
    check("ovf_after_drain", {63'd0, dl_overflow}, 1);

    // core read
    ack_dly = 2;
    do_read(AW'(32'h001234), 8'h5A);

    // contention: push and read request together while idle
    d0 = dl_done_cnt;
    ioctl_download = 1'b1;
    step();
    check("ovf_cleared", {63'd0, dl_overflow}, 0);
    push_wr(AW'(32'h300), 8'h77);
    ioctl_wr = 1'b1; ioctl_addr = AW'(32'h300); ioctl_dout = 8'h77;
    core_req = 1'b1;
    step();
    ioctl_wr = 1'b0;
    repeat (10) step();
    check("read_held", {63'd0, mem_req}, 0);
    ioctl_download = 1'b0;
    do_read(AW'(32'h000ABC), 8'hC3);
    check("cont_done_cnt", dl_done_cnt - d0, 1);
    repeat (20) step();

    // reset during a write with two bytes buffered
    ack_dly = 1;
    ack_hold = 1'b1;
    ioctl_download = 1'b1;
    step();
    push_wr(AW'(32'h400), 8'hD0);
    ioctl_wr = 1'b1; ioctl_addr = AW'(32'h400); ioctl_dout = 8'hD0;
    step();
    ioctl_addr = AW'(32'h401); ioctl_dout = 8'hD1;
    step();
    ioctl_wr = 1'b0;
    step();
    check("mid_wr_req", {63'd0, mem_req}, 1);
    d0 = dl_done_cnt;
    ioctl_download = 1'b0;
    reset = 1'b1;
    step();
    reset = 1'b0;
    ack_hold = 1'b0;
    check("mid_rst_req", {63'd0, mem_req}, 0);
    @(negedge clk_sys);
    n = 0;
    while (core_reset === 1'b1 && n < 200) begin
      n++;
      @(negedge clk_sys);
    end
    check("mid_rst_hold", n, 16);
    repeat (5) step();
    check("mid_rst_idle", {63'd0, mem_req}, 0);
    check("mid_rst_no_done", dl_done_cnt - d0, 0);

    check("exp_mem_left", exp_mem.size(), 0);
    check("exp_rd_left", exp_rd.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
